// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the MEM stage
// and the DMA/debug port.
package dm_arb_pkg;

    localparam int DM_AW_DEF = 12;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_sel_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle for dm_arbiter: CPU port, DMA port and the single-port memory side.
// slave = arbiter view, master = environment (pipeline, DMA, memory) view.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int AW = DM_AW_DEF
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_pc;
    logic          cpu_ready;
    logic [31:0]   cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [31:0]   dma_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ready, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ready, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dm_arb_starve_ctr.sv
// DMA starvation guard: counts conflict cycles the DMA loses and raises force_o
// so the next conflict goes to the DMA.
module dm_arb_starve_ctr
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic conflict_i,
    input  logic dma_req_i,
    input  logic dma_gnt_i,
    output logic force_o
);

    arb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (dma_gnt_i) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
        end else if (!dma_req_i) begin
            cnt_d = '0;
        end else if (conflict_i) begin
            // A conflict without a DMA grant is a cycle lost by the DMA.
            if (cnt_q == 4'(MAX_WAIT - 1)) begin
                state_d = ARB_FORCE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    assign force_o = (state_q == ARB_FORCE);

endmodule

// File: rtl/dm_arbiter.sv
// Fixed-priority (CPU first) arbiter for the single-port data memory with a DMA
// starvation guard. Optional store trace: define DM_ARB_TRACE_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = DM_AW_DEF
) (
    input logic         clk_i,
    input logic         reset_i,
    dm_arbiter_if.slave bus
);

    gnt_sel_e      sel;
    logic          force_w;
    logic          conflict;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rvld_q, rvld_d;
    logic [31:0]   rdata_q, rdata_d;

    assign conflict = bus.cpu_req && bus.dma_req;

    dm_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .conflict_i (conflict),
        .dma_req_i  (bus.dma_req),
        .dma_gnt_i  (sel == GNT_DMA),
        .force_o    (force_w)
    );

    // Grants are suppressed during reset so no write can reach the memory.
    always_comb begin
        sel = GNT_NONE;
        if (!reset_i) begin
            if (bus.cpu_req && !(bus.dma_req && force_w)) sel = GNT_CPU;
            else if (bus.dma_req)                       sel = GNT_DMA;
        end
    end

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bus.mem_we = 1'b0;
        unique case (sel)
            GNT_CPU: begin
                addr_d     = bus.cpu_addr;
                wdata_d    = bus.cpu_wdata;
                bus.mem_we = bus.cpu_we;
            end
            GNT_DMA: begin
                addr_d     = bus.dma_addr;
                wdata_d    = bus.dma_wdata;
                bus.mem_we = bus.dma_we;
            end
            default: ;
        endcase
    end

    assign rvld_d  = (sel == GNT_DMA) && !bus.dma_we;
    assign rdata_d = rvld_d ? bus.mem_rdata : rdata_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rvld_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rvld_q  <= rvld_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.mem_addr   = addr_d;
    assign bus.mem_wdata  = wdata_d;
    assign bus.cpu_ready  = !reset_i && ((sel == GNT_CPU) || !bus.cpu_req);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dma_gnt    = (sel == GNT_DMA);
    assign bus.dma_rvalid = rvld_q;
    assign bus.dma_rdata  = rdata_q;

`ifdef DM_ARB_TRACE_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i && bus.mem_we && (sel == GNT_CPU))
            $display("@%08h: *%08h <= %08h", bus.cpu_pc, 32'(bus.cpu_addr) << 2, bus.cpu_wdata);
        if (!reset_i && bus.mem_we && (sel == GNT_DMA))
            $display("DMA *%08h <= %08h", 32'(bus.dma_addr) << 2, bus.dma_wdata);
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.cpu_pc;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: stimulus pushes per-cycle expectations and
// expected DMA read data; a negedge monitor pops and compares.
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(12)) bus ();

    dm_arbiter #(.MAX_WAIT(4), .AW(12)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    logic [31:0] mem [0:4095];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    typedef struct {
        logic        ready, gnt, we;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        crd_chk;
        logic [31:0] crd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rv_q[$];
    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, expv, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            automatic exp_t e = exp_q.pop_front();
            chk("cpu_ready", 32'(bus.cpu_ready), 32'(e.ready));
            chk("dma_gnt",   32'(bus.dma_gnt),   32'(e.gnt));
            chk("mem_we",    32'(bus.mem_we),    32'(e.we));
            chk("mem_addr",  32'(bus.mem_addr),  32'(e.addr));
            if (e.we)      chk("mem_wdata", bus.mem_wdata, e.wd);
            if (e.crd_chk) chk("cpu_rdata", bus.cpu_rdata, e.crd);
        end
        if (bus.dma_rvalid) begin
            if (rv_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dma_rvalid: got 1 expected 0 at %0t", $time);
            end else begin
                chk("dma_rdata", bus.dma_rdata, rv_q.pop_front());
            end
        end
    end

    task automatic step(input logic cr, cw, input logic [11:0] ca, input logic [31:0] cd,
                        input logic dr, dw, input logic [11:0] da, input logic [31:0] dd,
                        input logic er, eg, ew, input logic [11:0] ea, input logic [31:0] ewd,
                        input logic ecc, input logic [31:0] ecrd,
                        input logic erv, input logic [31:0] erd);
        exp_t e;
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
        e.ready = er; e.gnt = eg; e.we = ew; e.addr = ea; e.wd = ewd;
        e.crd_chk = ecc; e.crd = ecrd;
        exp_q.push_back(e);
        if (erv) rv_q.push_back(erd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [11:0] ea);
        step(0,0,0,0, 0,0,0,0, 1,0,0,ea,0, 0,0, 0,0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.cpu_pc = 32'h0000_3004;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;

        #2;
        chk("rst_cpu_ready",  32'(bus.cpu_ready),  0);
        chk("rst_dma_gnt",    32'(bus.dma_gnt),    0);
        chk("rst_dma_rvalid", 32'(bus.dma_rvalid), 0);
        chk("rst_dma_rdata",  bus.dma_rdata,       0);
        chk("rst_mem_we",     32'(bus.mem_we),     0);
        chk("rst_mem_addr",   32'(bus.mem_addr),   0);
        chk("rst_mem_wdata",  bus.mem_wdata,       0);
        @(posedge clk); #1;
        reset = 0;

        // CPU store then load, DMA read and write
        step(1,1,12'h004,32'hDEADBEEF, 0,0,0,0, 1,0,1,12'h004,32'hDEADBEEF, 0,0, 0,0);
        idle(12'h004);
        step(1,0,12'h004,0, 0,0,0,0, 1,0,0,12'h004,0, 1,32'hDEADBEEF, 0,0);
        step(0,0,0,0, 1,0,12'h004,0, 1,1,0,12'h004,0, 0,0, 1,32'hDEADBEEF);
        idle(12'h004);
        step(0,0,0,0, 1,1,12'h008,32'h1111_1111, 1,1,1,12'h008,32'h1111_1111, 0,0, 0,0);
        step(1,0,12'h008,0, 0,0,0,0, 1,0,0,12'h008,0, 1,32'h1111_1111, 0,0);

        // Sustained conflict: CPU x4, DMA x1, repeated
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                step(1,0,12'h004,0, 1,0,12'h008,0, 1,0,0,12'h004,0, 1,32'hDEADBEEF, 0,0);
            step(1,0,12'h004,0, 1,0,12'h008,0, 0,1,0,12'h008,0, 0,0, 1,32'h1111_1111);
        end
        idle(12'h008);

        // DMA drops its request mid-conflict: counter must restart
        for (int k = 0; k < 2; k++)
            step(1,0,12'h004,0, 1,1,12'h020,32'hBAD, 1,0,0,12'h004,0, 0,0, 0,0);
        step(1,0,12'h004,0, 0,0,0,0, 1,0,0,12'h004,0, 0,0, 0,0);
        for (int k = 0; k < 3; k++)
            step(1,0,12'h004,0, 1,1,12'h020,32'hBAD, 1,0,0,12'h004,0, 0,0, 0,0);
        step(1,0,12'h020,0, 0,0,0,0, 1,0,0,12'h020,0, 1,32'h0, 0,0);
        for (int k = 0; k < 4; k++)
            step(1,0,12'h004,0, 1,1,12'h020,32'hBAD, 1,0,0,12'h004,0, 0,0, 0,0);
        step(1,0,12'h004,0, 1,1,12'h020,32'hBAD, 0,1,1,12'h020,32'hBAD, 0,0, 0,0);
        step(1,0,12'h020,0, 0,0,0,0, 1,0,0,12'h020,0, 1,32'hBAD, 0,0);

        // Back-to-back DMA reads
        step(0,0,0,0, 1,0,12'h004,0, 1,1,0,12'h004,0, 0,0, 1,32'hDEADBEEF);
        step(0,0,0,0, 1,0,12'h008,0, 1,1,0,12'h008,0, 0,0, 1,32'h1111_1111);
        idle(12'h008);

        // Reset right after a DMA read grant: pulse dropped, no write under reset
        step(0,0,0,0, 1,0,12'h020,0, 1,1,0,12'h020,0, 0,0, 0,0);
        reset = 1;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h030; bus.cpu_wdata = 32'h777;
        #1;
        chk("mid_rst_dma_rvalid", 32'(bus.dma_rvalid), 0);
        chk("mid_rst_dma_rdata",  bus.dma_rdata,       0);
        chk("mid_rst_cpu_ready",  32'(bus.cpu_ready),  0);
        chk("mid_rst_dma_gnt",    32'(bus.dma_gnt),    0);
        chk("mid_rst_mem_we",     32'(bus.mem_we),     0);
        chk("mid_rst_mem_addr",   32'(bus.mem_addr),   0);
        chk("mid_rst_mem_wdata",  bus.mem_wdata,       0);
        repeat (2) @(posedge clk);
        #1;
        chk("no_write_in_reset", mem[12'h030], 0);
        bus.cpu_req = 0; bus.cpu_we = 0; bus.dma_req = 0;
        reset = 0;
        idle(12'h000);
        step(1,0,12'h030,0, 0,0,0,0, 1,0,0,12'h030,0, 1,32'h0, 0,0);

        repeat (2) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("rv_q_drained",  rv_q.size(),  0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
